security_lock_param_core: RTL and testbench
===========================================

// Module: security_lock_param_core
// PURPOSE
//  Parametrised passcode-lock controller: CODE_LEN digits of DIGIT_W bits each, a user-changeable code,
//  a trial counter and a timed lockout. Sits between the debounced/edge-detected key/switch inputs and
//  the 7-seg/LED display layer of the board top; all outputs are registered.
// PARAMETERS
//  DIGIT_W       4                  width of one code digit
//  CODE_LEN      3                  digits per code (>=1)
//  MAX_TRIALS    3                  wrong submits allowed before lockout (>=1)
//  LOCKOUT_CYC   100_000_000        lockout duration in i_clk cycles (2 s @ 50 MHz, >=1)
//  DEFAULT_CODE  'h123              reset code, DIGIT_W*CODE_LEN bits, digit 0 = MS digit
// PORTS
//  i_clk           in   1                      system clock (CLOCK_50)
//  i_rst_n         in   1                      reset, synchronous, active-low
//  i_digit         in   DIGIT_W                digit value, sampled when i_digit_valid=1
//  i_digit_valid   in   1                      1-cycle pulse: accept i_digit
//  i_submit        in   1                      1-cycle pulse: submit entered digits
//  i_change_mode   in   1                      1-cycle pulse: request code change (OPEN only)
//  i_relock        in   1                      1-cycle pulse: relock (OPEN/SET only)
//  o_state         out  2                      0=ENTER 1=OPEN 2=SET 3=LOCKOUT
//  o_unlocked      out  1                      1 while state==OPEN
//  o_lockout       out  1                      1 while state==LOCKOUT
//  o_err_pulse     out  1                      1-cycle pulse on rejected submit
//  o_trials_left   out  $clog2(MAX_TRIALS+1)   remaining trials
//  o_entry_count   out  $clog2(CODE_LEN+1)     digits currently buffered
//  o_entered_code  out  DIGIT_W*CODE_LEN       entry buffer, for display
// BEHAVIOUR
//  - Reset (i_rst_n=0 at posedge): state=ENTER, code=DEFAULT_CODE, buffer=0, count=0,
//    trials_left=MAX_TRIALS, lockout timer=0, all pulse/flag outputs 0. Valid mid-operation, incl. LOCKOUT
//    and SET; a changed code is lost (reverts to DEFAULT_CODE).
//  - All outputs update on the edge that samples the input: visible 1 cycle after the input pulse.
//  - Digit entry (ENTER, SET only): buffer <= {buffer[MS digits shifted left], i_digit}, count+1.
//    At count==CODE_LEN, further digits are ignored (buffer and count hold). Ignored in OPEN/LOCKOUT.
//  - Priority per cycle: reset > i_submit > i_digit_valid; i_relock > i_change_mode. A digit arriving
//    in the same cycle as a submit is dropped.
//  - Every submit clears buffer and count, whatever its outcome.
//  - ENTER + submit: if count==CODE_LEN and buffer==code -> OPEN, trials_left=MAX_TRIALS.
//    Otherwise (wrong or short) -> o_err_pulse=1; if trials_left>1: trials_left-1, stay in ENTER;
//    if trials_left==1: trials_left=0, go to LOCKOUT, timer=LOCKOUT_CYC-1.
//  - LOCKOUT: every input ignored; timer decrements each cycle; on the cycle timer==0 -> ENTER,
//    trials_left=MAX_TRIALS. o_lockout is high for exactly LOCKOUT_CYC cycles.
//  - OPEN: i_relock -> ENTER (trials unchanged = MAX); i_change_mode -> SET (buffer, count cleared).
//    Digits/submits ignored.
//  - SET: submit with count==CODE_LEN -> code<=buffer, go to OPEN. Submit short -> o_err_pulse=1,
//    stay in SET, trials untouched. i_relock -> ENTER, code unchanged.
//  - Compare is a full-width equality on DIGIT_W*CODE_LEN bits; no wrap on count or trials (saturate).
// TESTING (DIGIT_W=4, CODE_LEN=3, MAX_TRIALS=3, LOCKOUT_CYC=8, DEFAULT_CODE='h123)
//  1 reset; digits 1,2,3; submit -> next cycle o_state=1, o_unlocked=1, o_trials_left=3, count=0.
//  2 submit 1,2,4 three times -> trials 2,1 with err pulses, then o_state=3, o_lockout=1 for
//    exactly 8 cycles; digits/submits during lockout ignored; then o_state=0, trials=3.
//  3 unlock; change_mode; 7,8,9; submit -> OPEN; relock; 1,2,3 submit -> err, trials=2;
//    7,8,9 submit -> OPEN.
//  4 digits 1,2 submit -> err, trials=2; digits 1,2,3,4,5 -> o_entered_code='h123, count=3;
//    submit -> OPEN.
//  5 digit_valid+submit same cycle after 1,2,3 -> digit dropped, unlock; change code to 'h789, enter
//    lockout, reset mid-lockout -> ENTER, trials=3, 1,2,3 opens (code back to default).

Source files
------------

// File: rtl/security_lock_param_core.sv
`default_nettype none
// ============================================================================
// Module   : security_lock_param_core
// Brief    : Parametrised passcode lock with changeable code, trial counter
//            and timed lockout; all outputs registered.
// Revision : 1.0
// ============================================================================
module security_lock_param_core #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 3,
  parameter int MAX_TRIALS  = 3,
  parameter int LOCKOUT_CYC = 100_000_000,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 'h123
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [DIGIT_W-1:0]                  i_digit,
  input  logic                                i_digit_valid,
  input  logic                                i_submit,
  input  logic                                i_change_mode,
  input  logic                                i_relock,
  output logic [1:0]                          o_state,
  output logic                                o_unlocked,
  output logic                                o_lockout,
  output logic                                o_err_pulse,
  output logic [$clog2(MAX_TRIALS+1)-1:0]     o_trials_left,
  output logic [$clog2(CODE_LEN+1)-1:0]       o_entry_count,
  output logic [DIGIT_W*CODE_LEN-1:0]         o_entered_code
);

  localparam int c_CODE_W  = DIGIT_W * CODE_LEN;
  localparam int c_TRIAL_W = $clog2(MAX_TRIALS + 1);
  localparam int c_CNT_W   = $clog2(CODE_LEN + 1);
  localparam int c_TMR_W   = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  localparam logic [c_TRIAL_W-1:0] c_MAX_TRIALS = c_TRIAL_W'(MAX_TRIALS);
  localparam logic [c_TRIAL_W-1:0] c_ONE_TRIAL  = c_TRIAL_W'(1);
  localparam logic [c_CNT_W-1:0]   c_CODE_LEN   = c_CNT_W'(CODE_LEN);
  localparam logic [c_TMR_W-1:0]   c_TMR_LOAD   = c_TMR_W'(LOCKOUT_CYC - 1);

  localparam logic [1:0] c_ENTER   = 2'd0;
  localparam logic [1:0] c_OPEN    = 2'd1;
  localparam logic [1:0] c_SET     = 2'd2;
  localparam logic [1:0] c_LOCKOUT = 2'd3;

  logic [1:0]           r_state;
  logic [c_CODE_W-1:0]  r_code;
  logic [c_CODE_W-1:0]  r_buf;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_TRIAL_W-1:0] r_trials;
  logic [c_TMR_W-1:0]   r_timer;
  logic                 r_err;
  logic                 r_unlocked;
  logic                 r_lockout;

  logic [1:0]           w_state_nxt;
  logic [c_CODE_W-1:0]  w_code_nxt;
  logic [c_CODE_W-1:0]  w_buf_nxt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [c_TRIAL_W-1:0] w_trials_nxt;
  logic [c_TMR_W-1:0]   w_timer_nxt;
  logic                 w_err_nxt;
  logic                 w_full;
  logic                 w_digit_ok;
  logic [c_CODE_W-1:0]  w_shifted;

  assign w_full     = (r_cnt == c_CODE_LEN);
  assign w_digit_ok = i_digit_valid && !w_full;
  // Oldest digit drops off the MS end; newest enters at the LS digit.
  assign w_shifted  = (r_buf << DIGIT_W) | c_CODE_W'(i_digit);

  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_buf_nxt    = r_buf;
    w_cnt_nxt    = r_cnt;
    w_trials_nxt = r_trials;
    w_timer_nxt  = r_timer;
    w_err_nxt    = 1'b0;
    case (r_state)
      c_ENTER: begin
        if (i_submit) begin
          w_buf_nxt = '0;
          w_cnt_nxt = '0;
          if (w_full && (r_buf == r_code)) begin
            w_state_nxt  = c_OPEN;
            w_trials_nxt = c_MAX_TRIALS;
          end else begin
            w_err_nxt = 1'b1;
            if (r_trials > c_ONE_TRIAL) begin
              w_trials_nxt = r_trials - c_ONE_TRIAL;
            end else begin
              w_trials_nxt = '0;
              w_state_nxt  = c_LOCKOUT;
              w_timer_nxt  = c_TMR_LOAD;
            end
          end
        end else if (w_digit_ok) begin
          w_buf_nxt = w_shifted;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      c_OPEN: begin
        if (i_relock) begin
          w_state_nxt = c_ENTER;
        end else if (i_change_mode) begin
          w_state_nxt = c_SET;
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      c_SET: begin
        // Leaving SET discards the partial new code so ENTER starts clean.
        if (i_relock) begin
          w_state_nxt = c_ENTER;
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (i_submit) begin
          w_buf_nxt = '0;
          w_cnt_nxt = '0;
          if (w_full) begin
            w_code_nxt  = r_buf;
            w_state_nxt = c_OPEN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (w_digit_ok) begin
          w_buf_nxt = w_shifted;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        if (r_timer == '0) begin
          w_state_nxt  = c_ENTER;
          w_trials_nxt = c_MAX_TRIALS;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= c_ENTER;
      r_code     <= DEFAULT_CODE;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_trials   <= c_MAX_TRIALS;
      r_timer    <= '0;
      r_err      <= 1'b0;
      r_unlocked <= 1'b0;
      r_lockout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_buf      <= w_buf_nxt;
      r_cnt      <= w_cnt_nxt;
      r_trials   <= w_trials_nxt;
      r_timer    <= w_timer_nxt;
      r_err      <= w_err_nxt;
      r_unlocked <= (w_state_nxt == c_OPEN);
      r_lockout  <= (w_state_nxt == c_LOCKOUT);
    end
  end

  assign o_state        = r_state;
  assign o_unlocked     = r_unlocked;
  assign o_lockout      = r_lockout;
  assign o_err_pulse    = r_err;
  assign o_trials_left  = r_trials;
  assign o_entry_count  = r_cnt;
  assign o_entered_code = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_security_lock_param_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_security_lock_param_core
// Brief    : Directed plus randomized bench for security_lock_param_core,
//            checked every cycle against a queue-based lock model.
// Revision : 1.0
// ============================================================================
module tb_security_lock_param_core;

  localparam int L_CYC = 8;
  localparam int MAXT  = 3;
  localparam int LEN   = 3;

  logic        r_clk = 1'b0;
  logic        r_rst_n = 1'b0;
  logic [3:0]  r_digit = '0;
  logic        r_dv = 1'b0;
  logic        r_sub = 1'b0;
  logic        r_cm = 1'b0;
  logic        r_rl = 1'b0;
  logic [1:0]  w_state;
  logic        w_unlocked;
  logic        w_lockout;
  logic        w_err;
  logic [1:0]  w_trials;
  logic [1:0]  w_count;
  logic [11:0] w_entered;

  int n_pass = 0;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: state number, stored code, digit queue, trials, cycles of lockout left.
  int          m_state;
  logic [11:0] m_code;
  int          m_q[$];
  int          m_trials;
  int          m_rem;
  bit          m_err;

  security_lock_param_core #(
    .DIGIT_W(4), .CODE_LEN(LEN), .MAX_TRIALS(MAXT), .LOCKOUT_CYC(L_CYC), .DEFAULT_CODE(12'h123)
  ) dut (
    .i_clk(r_clk), .i_rst_n(r_rst_n), .i_digit(r_digit), .i_digit_valid(r_dv),
    .i_submit(r_sub), .i_change_mode(r_cm), .i_relock(r_rl),
    .o_state(w_state), .o_unlocked(w_unlocked), .o_lockout(w_lockout),
    .o_err_pulse(w_err), .o_trials_left(w_trials), .o_entry_count(w_count),
    .o_entered_code(w_entered)
  );

  always #5 r_clk = ~r_clk;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] q_value();
    logic [11:0] v = '0;
    foreach (m_q[i]) v = (v << 4) | 12'(m_q[i]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst_n, input bit dv, input int d,
                              input bit sub, input bit cm, input bit rl);
    if (!rst_n) begin
      m_state = 0; m_code = 12'h123; m_q.delete(); m_trials = MAXT; m_rem = 0; m_err = 0;
      return;
    end
    m_err = 0;
    case (m_state)
      0: begin
        if (sub) begin
          bit ok;
          ok = (m_q.size() == LEN) && (q_value() == m_code);
          m_q.delete();
          if (ok) begin
            m_state = 1; m_trials = MAXT;
          end else begin
            m_err = 1;
            if (m_trials > 1) m_trials--;
            else begin m_trials = 0; m_state = 3; m_rem = L_CYC; end
          end
        end else if (dv && m_q.size() < LEN) m_q.push_back(d);
      end
      1: begin
        if (rl) m_state = 0;
        else if (cm) begin m_state = 2; m_q.delete(); end
      end
      2: begin
        if (rl) begin m_state = 0; m_q.delete(); end
        else if (sub) begin
          if (m_q.size() == LEN) begin m_code = q_value(); m_state = 1; end
          else m_err = 1;
          m_q.delete();
        end else if (dv && m_q.size() < LEN) m_q.push_back(d);
      end
      default: begin
        m_rem--;
        if (m_rem == 0) begin m_state = 0; m_trials = MAXT; end
      end
    endcase
  endtask

  task automatic step(input bit rst_n, input bit dv, input int d,
                      input bit sub, input bit cm, input bit rl);
    r_rst_n = rst_n; r_dv = dv; r_digit = 4'(d); r_sub = sub; r_cm = cm; r_rl = rl;
    @(posedge r_clk);
    model_update(rst_n, dv, d, sub, cm, rl);
    cyc++;
    #1;
    chk("state",    32'(w_state),    32'(m_state));
    chk("unlocked", 32'(w_unlocked), 32'(m_state == 1));
    chk("lockout",  32'(w_lockout),  32'(m_state == 3));
    chk("err",      32'(w_err),      32'(m_err));
    chk("trials",   32'(w_trials),   32'(m_trials));
    chk("count",    32'(w_count),    32'(m_q.size()));
    chk("entered",  32'(w_entered),  32'(q_value()));
  endtask

  task automatic dig(input int d);  step(1, 1, d, 0, 0, 0); endtask
  task automatic submit();          step(1, 0, 0, 1, 0, 0); endtask
  task automatic relock();          step(1, 0, 0, 0, 0, 1); endtask
  task automatic chmode();          step(1, 0, 0, 0, 1, 0); endtask
  task automatic do_reset();        step(0, 0, 0, 0, 0, 0); endtask
  task automatic code3(input int a, input int b, input int c);
    dig(a); dig(b); dig(c); submit();
  endtask

  initial begin
    int lock_cycles;
    int guard;

    // 1: reset and unlock with the default code
    do_reset(); do_reset();
    chk("rst_state", 32'(w_state), 32'd0);
    chk("rst_trials", 32'(w_trials), 32'd3);
    chk("rst_count", 32'(w_count), 32'd0);
    code3(1, 2, 3);
    chk("t1_open", 32'(w_state), 32'd1);
    chk("t1_unlocked", 32'(w_unlocked), 32'd1);
    chk("t1_trials", 32'(w_trials), 32'd3);
    relock();

    // 2: three wrong codes, then a lockout of exactly L_CYC cycles
    code3(1, 2, 4);
    chk("t2_err1", 32'(w_err), 32'd1);
    chk("t2_tr2", 32'(w_trials), 32'd2);
    code3(1, 2, 4);
    chk("t2_tr1", 32'(w_trials), 32'd1);
    code3(1, 2, 4);
    chk("t2_lock", 32'(w_state), 32'd3);
    lock_cycles = (w_lockout === 1'b1) ? 1 : 0;
    guard = 0;
    while (w_lockout === 1'b1 && guard < 20) begin
      step(1, 1, 1 + (guard % 3), guard[1], guard[2], guard[0]);
      if (w_lockout === 1'b1) lock_cycles++;
      guard++;
    end
    chk("t2_lock_len", 32'(lock_cycles), 32'(L_CYC));
    chk("t2_enter", 32'(w_state), 32'd0);
    chk("t2_trials", 32'(w_trials), 32'd3);

    // 3: change code to 789, old code rejected, new code accepted
    code3(1, 2, 3);
    chmode();
    chk("t3_set", 32'(w_state), 32'd2);
    code3(7, 8, 9);
    chk("t3_open", 32'(w_state), 32'd1);
    relock();
    code3(1, 2, 3);
    chk("t3_err", 32'(w_err), 32'd1);
    chk("t3_trials", 32'(w_trials), 32'd2);
    code3(7, 8, 9);
    chk("t3_open2", 32'(w_state), 32'd1);

    // 4: short submit, then overfull entry saturates at three digits
    do_reset();
    dig(1); dig(2); submit();
    chk("t4_err", 32'(w_err), 32'd1);
    chk("t4_trials", 32'(w_trials), 32'd2);
    dig(1); dig(2); dig(3); dig(4); dig(5);
    chk("t4_entered", 32'(w_entered), 32'h123);
    chk("t4_count", 32'(w_count), 32'd3);
    submit();
    chk("t4_open", 32'(w_state), 32'd1);

    // 5: digit dropped under submit; reset in lockout restores default code
    relock();
    dig(1); dig(2); dig(3); step(1, 1, 5, 1, 0, 0);
    chk("t5_open", 32'(w_state), 32'd1);
    chmode(); code3(7, 8, 9);
    relock();
    code3(1, 2, 3); code3(1, 2, 3); code3(1, 2, 3);
    chk("t5_lock", 32'(w_state), 32'd3);
    step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
    do_reset();
    chk("t5_rst_state", 32'(w_state), 32'd0);
    chk("t5_rst_trials", 32'(w_trials), 32'd3);
    code3(1, 2, 3);
    chk("t5_open2", 32'(w_state), 32'd1);

    // Randomized phase, checked against the model every cycle
    for (int i = 0; i < 600; i++) begin
      bit rst_n, dv, sub, cm, rl;
      int d;
      rst_n = ($urandom_range(0, 199) != 0);
      dv    = $urandom_range(0, 1);
      d     = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 15));
      sub   = ($urandom_range(0, 4) == 0);
      cm    = ($urandom_range(0, 7) == 0);
      rl    = !sub && ($urandom_range(0, 9) == 0);
      step(rst_n, dv, d, sub, cm, rl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
